// File: rtl/keypad_bcd_encoder.sv
// Ten-key front end for the cook-timer digit chain: synchronizes and debounces
// one-hot digit keys, encodes the accepted key to BCD and tracks digits entered.
module keypad_bcd_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 3
) (
    input  logic       clock,
    input  logic       Cn,
    input  logic [9:0] keys,
    input  logic       enable,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       load,
    output logic       reject,
    output logic [1:0] count,
    output logic       full
);

    localparam int              CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]      COUNT_MAX = 2'(MAX_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        WAIT_RELEASE
    } state_t;

    state_t        state, state_n;
    logic [9:0]    sync1, ks;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    cand, cand_n;
    logic [3:0]    digit_n;
    logic [1:0]    count_n;
    logic          load_n, reject_n;
    logic          accept;
    logic [3:0]    key_code, ones;
    logic          key_single;

    always_ff @(posedge clock or negedge Cn) begin
        if (!Cn) begin
            sync1  <= '0;
            ks     <= '0;
            state  <= IDLE;
            cnt    <= '0;
            cand   <= '0;
            digit  <= '0;
            count  <= '0;
            load   <= 1'b0;
            reject <= 1'b0;
        end else begin
            sync1  <= keys;
            ks     <= sync1;
            state  <= state_n;
            cnt    <= cnt_n;
            cand   <= cand_n;
            digit  <= digit_n;
            count  <= count_n;
            load   <= load_n;
            reject <= reject_n;
        end
    end

    // Multi-key patterns are never single, so they fall through as "no key".
    always_comb begin
        key_code = '0;
        ones     = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (ks[i]) begin
                key_code = 4'(i);
                ones     = ones + 4'd1;
            end
        end
        key_single = (ones == 4'd1);
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cand_n   = cand;
        digit_n  = digit;
        count_n  = count;
        load_n   = 1'b0;
        reject_n = 1'b0;
        accept   = 1'b0;

        case (state)
            IDLE: begin
                if (key_single) begin
                    cand_n  = key_code;
                    cnt_n   = CW'(1);
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!key_single || key_code != cand) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    accept  = 1'b1;
                    cnt_n   = '0;
                    state_n = WAIT_RELEASE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT_RELEASE: begin
                if (ks == '0) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end else begin
                    cnt_n = '0;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase

        // clr wins over acceptance; a refused press still reports reject.
        if (accept) begin
            if (clr) begin
                count_n  = '0;
                reject_n = 1'b1;
            end else if (enable && count < COUNT_MAX) begin
                digit_n = cand;
                count_n = count + 2'd1;
                load_n  = 1'b1;
            end else begin
                reject_n = 1'b1;
            end
        end else if (clr) begin
            count_n = '0;
        end
    end

    assign full = (count == COUNT_MAX);

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Self-checking bench for keypad_bcd_encoder: directed scenarios plus random
// key traffic checked against a run-length behavioural model.
module tb_keypad_bcd_encoder;

    localparam int D   = 4;
    localparam int MAX = 3;

    logic       clock, Cn, enable, clr;
    logic [9:0] keys;
    logic [3:0] digit;
    logic       load, reject, full;
    logic [1:0] count;

    int errors = 0;
    int checks = 0;

    // Model state: synchronizer copies, candidate run length, release run length.
    logic [9:0] m_s1, m_s2, m_key;
    int         m_len, m_zlen;
    bit         m_armed;
    int         m_digit, m_count;
    bit         m_load, m_reject;

    keypad_bcd_encoder #(.DEBOUNCE_CYCLES(D), .MAX_DIGITS(MAX)) dut (
        .clock  (clock),
        .Cn     (Cn),
        .keys   (keys),
        .enable (enable),
        .clr    (clr),
        .digit  (digit),
        .load   (load),
        .reject (reject),
        .count  (count),
        .full   (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_key = '0;
        m_len = 0; m_zlen = 0; m_armed = 1'b1;
        m_digit = 0; m_count = 0; m_load = 1'b0; m_reject = 1'b0;
    endtask

    // A press is accepted once the same single key has been seen D samples in a
    // row from an armed state; a conflicting sample cancels the run and is
    // itself discarded. Re-arming needs D consecutive all-clear samples.
    task automatic model_step();
        logic [9:0] s;
        bit         accept, was_armed;
        int         k;
        if (!Cn) begin
            model_reset();
            return;
        end
        s = m_s2;
        accept = 1'b0;
        was_armed = m_armed;
        m_load = 1'b0;
        m_reject = 1'b0;
        k = 0;
        for (int i = 0; i < 10; i++) if (m_key[i]) k = i;
        if (was_armed) begin
            if ($countones(s) == 1) begin
                if (m_len > 0 && s == m_key) m_len++;
                else if (m_len > 0) m_len = 0;
                else begin m_len = 1; m_key = s; end
                if (m_len == D) begin
                    accept = 1'b1;
                    m_armed = 1'b0;
                    m_zlen = 0;
                    m_len = 0;
                    for (int i = 0; i < 10; i++) if (m_key[i]) k = i;
                end
            end else begin
                m_len = 0;
            end
        end else begin
            if (s == '0) m_zlen++;
            else m_zlen = 0;
            if (m_zlen == D) begin m_armed = 1'b1; m_len = 0; end
        end
        if (accept) begin
            if (clr) begin m_count = 0; m_reject = 1'b1; end
            else if (enable && m_count < MAX) begin
                m_digit = k; m_count++; m_load = 1'b1;
            end else m_reject = 1'b1;
        end else if (clr) begin
            m_count = 0;
        end
        m_s2 = m_s1;
        m_s1 = keys;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic release_keys();
        keys = '0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        Cn = 1'b0; keys = '0; enable = 1'b1; clr = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({digit, load, reject, count, full} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got digit=%0d load=%0b reject=%0b count=%0d full=%0b, want all 0",
                     digit, load, reject, count, full);
        end
        repeat (2) tick();
        Cn = 1'b1;
    endtask

    task automatic test_clean_press();
        keys = 10'b0000100000;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (load !== (i == 6) || reject !== 1'b0) begin
                errors++;
                $display("FAIL clean_press edge %0d: got load=%0b reject=%0b, want load=%0b reject=0",
                         i, load, reject, i == 6);
            end
        end
        checks++;
        if (digit !== 4'd5 || count !== 2'd1 || full !== 1'b0) begin
            errors++;
            $display("FAIL clean_press_state: got digit=%0d count=%0d full=%0b, want 5 1 0", digit, count, full);
        end
        release_keys();
    endtask

    task automatic test_glitch();
        keys = 10'b1 << 7;
        repeat (3) tick();
        keys = '0;
        tick();
        keys = 10'b1 << 7;
        for (int i = 5; i <= 14; i++) begin
            tick();
            checks++;
            if (load !== (i == 10) || reject !== 1'b0) begin
                errors++;
                $display("FAIL glitch edge %0d: got load=%0b reject=%0b, want load=%0b reject=0",
                         i, load, reject, i == 10);
            end
        end
        checks++;
        if (digit !== 4'd7 || count !== 2'd2) begin
            errors++;
            $display("FAIL glitch_state: got digit=%0d count=%0d, want 7 2", digit, count);
        end
        release_keys();
    endtask

    task automatic test_fill();
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (count !== 2'd0) begin
            errors++;
            $display("FAIL clr_idle: got count=%0d, want 0", count);
        end
        for (int k = 1; k <= 4; k++) begin
            keys = 10'b1 << k;
            repeat (6) tick();
            checks++;
            if (load !== (k <= 3) || reject !== (k == 4)) begin
                errors++;
                $display("FAIL fill key %0d: got load=%0b reject=%0b, want load=%0b reject=%0b",
                         k, load, reject, k <= 3, k == 4);
            end
            release_keys();
        end
        checks++;
        if (count !== 2'd3 || full !== 1'b1 || digit !== 4'd3) begin
            errors++;
            $display("FAIL fill_state: got count=%0d full=%0b digit=%0d, want 3 1 3", count, full, digit);
        end
    endtask

    task automatic test_enable();
        clr = 1'b1; tick(); clr = 1'b0;
        enable = 1'b0;
        keys = 10'b1 << 9;
        repeat (6) tick();
        checks++;
        if (load !== 1'b0 || reject !== 1'b1 || digit !== 4'd3 || count !== 2'd0) begin
            errors++;
            $display("FAIL disabled_press: got load=%0b reject=%0b digit=%0d count=%0d, want 0 1 3 0",
                     load, reject, digit, count);
        end
        release_keys();
        enable = 1'b1;
        keys = 10'b1 << 9;
        repeat (6) tick();
        checks++;
        if (load !== 1'b1 || reject !== 1'b0 || digit !== 4'd9 || count !== 2'd1) begin
            errors++;
            $display("FAIL enabled_press: got load=%0b reject=%0b digit=%0d count=%0d, want 1 0 9 1",
                     load, reject, digit, count);
        end
        release_keys();
    endtask

    task automatic test_multi();
        keys = (10'b1 << 2) | (10'b1 << 6);
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (load !== 1'b0 || reject !== 1'b0) begin
                errors++;
                $display("FAIL multi edge %0d: got load=%0b reject=%0b, want 0 0", i, load, reject);
            end
        end
        keys = 10'b1 << 2;
        repeat (6) tick();
        checks++;
        if (load !== 1'b1 || digit !== 4'd2 || count !== 2'd2) begin
            errors++;
            $display("FAIL multi_then_single: got load=%0b digit=%0d count=%0d, want 1 2 2", load, digit, count);
        end
        release_keys();
    endtask

    task automatic test_reset_mid_press();
        keys = 10'b1 << 8;
        repeat (4) tick();
        Cn = 1'b0;
        #1;
        checks++;
        if ({digit, load, reject, count, full} !== 9'd0) begin
            errors++;
            $display("FAIL reset_mid_press: got digit=%0d load=%0b reject=%0b count=%0d full=%0b, want all 0",
                     digit, load, reject, count, full);
        end
        tick();
        Cn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (load !== (i == 6) || reject !== 1'b0) begin
                errors++;
                $display("FAIL held_after_reset edge %0d: got load=%0b reject=%0b, want load=%0b reject=0",
                         i, load, reject, i == 6);
            end
        end
        checks++;
        if (digit !== 4'd8 || count !== 2'd1) begin
            errors++;
            $display("FAIL held_after_reset_state: got digit=%0d count=%0d, want 8 1", digit, count);
        end
        release_keys();
    endtask

    task automatic test_clr_on_accept();
        keys = 10'b1 << 4;
        repeat (5) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (reject !== 1'b1 || load !== 1'b0 || count !== 2'd0 || digit !== 4'd8) begin
            errors++;
            $display("FAIL clr_on_accept: got reject=%0b load=%0b count=%0d digit=%0d, want 1 0 0 8",
                     reject, load, count, digit);
        end
        release_keys();
    endtask

    task automatic test_random();
        int a, b;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                a = $urandom_range(0, 9);
                if (a < 3) keys = '0;
                else if (a < 8) keys = 10'b1 << $urandom_range(0, 9);
                else begin
                    a = $urandom_range(0, 9);
                    b = (a + $urandom_range(1, 9)) % 10;
                    keys = (10'b1 << a) | (10'b1 << b);
                end
            end
            enable = ($urandom_range(0, 7) != 0);
            clr    = ($urandom_range(0, 39) == 0);
            tick();
            checks++;
            if (digit !== 4'(m_digit) || load !== m_load || reject !== m_reject ||
                count !== 2'(m_count) || full !== (m_count == MAX)) begin
                errors++;
                $display("FAIL random cycle %0d: got digit=%0d load=%0b reject=%0b count=%0d full=%0b, want %0d %0b %0b %0d %0b",
                         n, digit, load, reject, count, full,
                         m_digit, m_load, m_reject, m_count, m_count == MAX);
            end
        end
        clr = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_fill();
        test_enable();
        test_multi();
        test_reset_mid_press();
        test_clr_on_accept();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
